// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - instruction fetch/issue unit with memory req/ack and decoder valid/ready
module busca_instrucao #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 8,
  parameter logic [INSTR_W-1:0] HALT_OP = 8'hFF,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instru,
  output logic               instru_valid,
  input  logic               instru_ready,
  input  logic               pula,
  input  logic [ADDR_W-1:0]  alvo,
  output logic               escritaPC,
  output logic [ADDR_W-1:0]  pc,
  output logic               parado,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

  state_t state, state_next;

  logic ack_seen;
  logic issue_hs;
  logic is_halt;

  assign ack_seen = (state == FETCH) && mem_ack;
  assign issue_hs = (state == ISSUE) && instru_ready;
  assign is_halt  = (instru == HALT_OP);

  assign mem_req      = (state == FETCH);
  assign instru_valid = (state == ISSUE);
  assign parado       = (state == HALTED);
  assign mem_addr     = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (run) state_next = FETCH;
      FETCH:  if (mem_ack) state_next = ISSUE;
      ISSUE: begin
        if (instru_ready) begin
          if (is_halt)  state_next = HALTED;
          else if (run) state_next = FETCH;
          else          state_next = IDLE;
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // escritaPC is registered so it marks the cycle after the PC update edge
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instru      <= '0;
      instr_count <= '0;
      escritaPC   <= 1'b0;
    end else begin
      escritaPC <= 1'b0;
      if (ack_seen) begin
        instru <= mem_data;
      end
      if (issue_hs) begin
        if (instr_count != {CNT_W{1'b1}}) begin
          instr_count <= instr_count + CNT_W'(1);
        end
        if (!is_halt) begin
          pc        <= pula ? alvo : pc + ADDR_W'(1);
          escritaPC <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// tb/tb_busca_instrucao.sv - directed self-checking bench for busca_instrucao
module tb_busca_instrucao;

  logic        clk;
  logic        reset;
  logic        run;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  instru;
  logic        instru_valid;
  logic        instru_ready;
  logic        pula;
  logic [7:0]  alvo;
  logic        escritaPC;
  logic [7:0]  pc;
  logic        parado;
  logic [15:0] instr_count;

  int checks;
  int failures;

  busca_instrucao dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instru(instru), .instru_valid(instru_valid), .instru_ready(instru_ready),
    .pula(pula), .alvo(alvo), .escritaPC(escritaPC), .pc(pc),
    .parado(parado), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // from FETCH: ack same cycle with data, land in ISSUE
  task automatic fetch_now(input logic [7:0] d);
    mem_ack = 1'b1;
    mem_data = d;
    tick();
    mem_ack = 1'b0;
    check_eq("issue_instru", instru, d);
    check_eq("issue_valid", instru_valid, 1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_data = 8'h00;
    instru_ready = 1'b0; pula = 1'b0; alvo = 8'h00;
    tick(); tick();
    check_eq("rst_req", mem_req, 0);
    check_eq("rst_valid", instru_valid, 0);
    check_eq("rst_parado", parado, 0);
    check_eq("rst_escrita", escritaPC, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_instru", instru, 0);
    check_eq("rst_count", instr_count, 0);

    reset = 1'b0; run = 1'b1; instru_ready = 1'b1;
    tick();
    check_eq("first_req", mem_req, 1);
    check_eq("first_addr", mem_addr, 0);

    // back-to-back issue, ack in the request cycle
    for (int i = 0; i < 3; i++) begin
      fetch_now(8'(i));
      check_eq("issue_noreq", mem_req, 0);
      tick();
      check_eq("seq_escrita", escritaPC, 1);
      check_eq("seq_pc", pc, i + 1);
      check_eq("seq_addr", mem_addr, i + 1);
      check_eq("seq_req", mem_req, 1);
    end
    check_eq("seq_count", instr_count, 3);

    // 3-cycle memory latency, then decoder stalls 4 cycles
    for (int c = 0; c < 2; c++) begin
      check_eq("lat_req", mem_req, 1);
      check_eq("lat_addr", mem_addr, 3);
      tick();
    end
    check_eq("lat_req3", mem_req, 1);
    instru_ready = 1'b0;
    fetch_now(8'h10);
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("stall_valid", instru_valid, 1);
      check_eq("stall_instru", instru, 8'h10);
    end
    instru_ready = 1'b1;
    tick();
    check_eq("stall_pc", pc, 4);
    check_eq("stall_count", instr_count, 4);

    // pula outside the handshake is ignored
    pula = 1'b1; alvo = 8'h80;
    fetch_now(8'h20);
    pula = 1'b0;
    tick();
    check_eq("pula_ignored_pc", pc, 5);

    // jump at pc=5
    fetch_now(8'h21);
    pula = 1'b1; alvo = 8'h40;
    tick();
    pula = 1'b0;
    check_eq("jump_addr", mem_addr, 8'h40);
    check_eq("jump_escrita", escritaPC, 1);

    // jump to 0xFF then wrap
    fetch_now(8'h22);
    pula = 1'b1; alvo = 8'hFF;
    tick();
    pula = 1'b0;
    check_eq("to_ff_pc", pc, 8'hFF);
    fetch_now(8'h23);
    tick();
    check_eq("wrap_pc", pc, 0);
    check_eq("wrap_addr", mem_addr, 0);
    check_eq("wrap_escrita", escritaPC, 1);
    check_eq("wrap_count", instr_count, 8);

    // run=0 at handshake goes to IDLE
    fetch_now(8'h30);
    run = 1'b0;
    tick();
    check_eq("stop_req", mem_req, 0);
    check_eq("stop_valid", instru_valid, 0);
    check_eq("stop_pc", pc, 1);
    tick();
    check_eq("idle_req", mem_req, 0);
    run = 1'b1;
    tick();
    check_eq("resume_req", mem_req, 1);
    check_eq("resume_addr", mem_addr, 1);

    // halt at address 3
    fetch_now(8'h31);
    tick();
    fetch_now(8'h32);
    tick();
    check_eq("pre_halt_pc", pc, 3);
    fetch_now(8'hFF);
    tick();
    check_eq("halt_parado", parado, 1);
    check_eq("halt_pc", pc, 3);
    check_eq("halt_escrita", escritaPC, 0);
    check_eq("halt_count", instr_count, 12);
    mem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("halt_noreq", mem_req, 0);
      check_eq("halt_hold", parado, 1);
    end
    mem_ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("unhalt_parado", parado, 0);
    check_eq("unhalt_pc", pc, 0);

    // reset mid-fetch, then stale ack
    tick();
    check_eq("mf_req", mem_req, 1);
    fetch_now(8'h55);
    tick();
    check_eq("mf_count", instr_count, 1);
    check_eq("mf_req2", mem_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    mem_ack = 1'b1; mem_data = 8'h77;
    tick();
    mem_ack = 1'b0;
    check_eq("stale_req", mem_req, 0);
    check_eq("stale_valid", instru_valid, 0);
    check_eq("stale_instru", instru, 0);
    check_eq("stale_count", instr_count, 0);
    check_eq("stale_pc", pc, 0);
    tick();
    check_eq("stale_valid2", instru_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
